mono_data_tx_emu: RTL and testbench
===================================

# mono_data_tx_emu

Chip-side emulator of the MONOPIX token/read/freeze serial readout. It is the transmitting end of the link that the mono data receiver samples. It buffers injected hit words, raises TX_TOKEN while hits are pending, and on each TX_READ rising edge shifts one 30-bit word out MSB-first, gray-coding the timestamps on the way out. It is used in simulation and as an FPGA loopback source to test the receive chain without a sensor.

## Interface
- DEPTH, 16: hit buffer entries; must be a power of 2 and at least 2.
- DATA_DLY, 0: idle cycles between the detected TX_READ edge and the first data bit (0–15).
- CLK  in  1  single clock. Also the serial bit clock.
- RST  in  1  reset, synchronous to CLK, active-high.
- CONF_EN  in  1  enables TX_TOKEN and READ response.
- CONF_DISABLE_GRAY_ENC  in  1  when 1, LE and TE are sent as binary.
- HIT_WRITE  in  1  push HIT_DATA.
- HIT_DATA  in  30  {le[7:0], te[7:0], row[7:0], col[5:0]}, binary.
- HIT_FULL  out  1  buffer full (count == DEPTH).
- TX_FREEZE  in  1  holds TX_TOKEN at its current value.
- TX_READ  in  1  read request. One word per rising edge.
- TX_TOKEN  out  1  hits pending.
- TX_DATA  out  1  serial data, MSB first.
- BUSY  out  1  transmission in progress (WAIT or SHIFT state).
- LOST_CNT  out  8  saturating count of dropped writes.
- EMPTY_READ_CNT  out  8  saturating count of reads issued while the buffer was empty.

## Operation
- **Buffer.** FIFO of DEPTH entries with a count register.
  - A write when full, with no pop in the same cycle, is dropped and increments LOST_CNT. LOST_CNT saturates at 255.
  - A write and a pop in the same cycle with a full buffer are both honoured; count stays at DEPTH.
  - Writes are accepted regardless of CONF_EN or TX_FREEZE.
- **Encoding.** Applied at pop time.
  - Gray code: g = b ^ (b >> 1) on le and te. Each is 8 bits in and 8 bits out.
  - row and col pass through unchanged.
  - CONF_DISABLE_GRAY_ENC bypasses the gray encoding.
- **Token logic.** Evaluated every cycle, in priority order:
  - If !CONF_EN, TX_TOKEN ← 0.
  - Else if TX_FREEZE, TX_TOKEN holds its value.
  - Else TX_TOKEN ← (count != 0).
- **Read edge.** read_q is a registered copy of TX_READ. An edge is TX_READ & !read_q & CONF_EN, and is acted on only in IDLE. Edges seen in WAIT or SHIFT are ignored and not queued.
- **State machine.** States are IDLE, WAIT and SHIFT.
  - IDLE → edge: pop the head into the shift register. If the buffer is empty, load 30'h0 and increment EMPTY_READ_CNT (saturating). Go to WAIT if DATA_DLY > 0, otherwise to SHIFT.
  - WAIT → count DATA_DLY cycles, then go to SHIFT.
  - SHIFT → a 5-bit bit counter runs from 29 down to 0. TX_DATA = sr[29]; shift left every cycle. After bit 0 is sent, go to IDLE.
  - TX_DATA = 0 outside SHIFT.
- **Reset.**
  - RST clears the FIFO, the counters and read_q, and returns the state machine to IDLE.
  - All outputs read 0 after reset: TX_TOKEN, TX_DATA, BUSY, HIT_FULL, LOST_CNT and EMPTY_READ_CNT.
  - An RST asserted mid-SHIFT aborts the word; TX_DATA = 0 the next cycle.

## Timing
- All outputs are registered.
- Write latency: a write at edge k into an empty buffer makes count = 1 after edge k. TX_TOKEN = 1 after edge k+1, provided FREEZE = 0 and EN = 1.
- Read latency: the edge is detected at clock edge n. Bit 29 is on TX_DATA during cycle n+1+DATA_DLY. Bit 0 is on TX_DATA during cycle n+30+DATA_DLY. BUSY is high over exactly those cycles (WAIT plus SHIFT).
- The pop takes effect at edge n. TX_TOKEN falls at edge n+1 if the buffer emptied and FREEZE = 0.
- Back-to-back reads: the earliest accepted next edge is the first IDLE cycle after bit 0.

## Structure
- Package mono_tx_pkg holds:
  - field widths: LE_W = 8, TE_W = 8, ROW_W = 8, COL_W = 6, WORD_W = 30;
  - the state encoding localparams: IDLE, WAIT, SHIFT (one-hot).
- Sub-module gray_enc8: combinational 8-bit binary-to-gray encoder, instantiated twice (le and te).
- The FIFO is inline: register array plus pointers and count.

## Test plan
- Reset: assert RST for 3 cycles → TX_TOKEN = 0, TX_DATA = 0, BUSY = 0, HIT_FULL = 0, LOST_CNT = 0, EMPTY_READ_CNT = 0.
- Gray path: write le = 0x05, te = 0x03, row = 0x12, col = 0x2A. TX_TOKEN rises 2 cycles later. Pulse TX_READ → 30 serial bits equal 0x1C084AA, first bit 1 cycle after the edge (DATA_DLY = 0). TX_TOKEN drops one cycle after the edge.
- Gray bypass: same hit with CONF_DISABLE_GRAY_ENC = 1 → serial word 0x140C4AA. With DATA_DLY = 3, the first bit appears 4 cycles after the edge.
- Overflow: DEPTH = 16, write 18 hits without reading → HIT_FULL = 1, LOST_CNT = 2. Then read 16 times → words 1–16 in order, TX_TOKEN = 0.
- Freeze and empty read:
  - TX_FREEZE = 1 while the last word is popped → TX_TOKEN stays 1 until FREEZE drops, then falls one cycle later.
  - A read on an empty buffer → 30 zero bits, BUSY high for 30 cycles, EMPTY_READ_CNT = 1.
  - A TX_READ re-pulsed during SHIFT → ignored.
- Reset mid-operation: RST at bit 15 of a word → TX_DATA = 0 and BUSY = 0 the next cycle, FIFO empty, TX_TOKEN = 0.

Source files
------------

// File: rtl/mono_tx_pkg.sv
// Shared widths and state encoding for the MONOPIX serial readout emulator.
package mono_tx_pkg;

  localparam int LE_W   = 8;
  localparam int TE_W   = 8;
  localparam int ROW_W  = 8;
  localparam int COL_W  = 6;
  localparam int WORD_W = 30;

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    WAIT  = 3'b010,
    SHIFT = 3'b100
  } tx_state_t;

endpackage

// File: rtl/gray_enc8.sv
// Combinational 8-bit binary-to-gray encoder.
module gray_enc8 (
  input  logic [7:0] bin,
  output logic [7:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/mono_data_tx_emu.sv
// MONOPIX token/read/freeze transmitter emulator: buffers hit words and shifts one
// 30-bit word MSB-first per TX_READ rising edge, gray-coding LE/TE at pop time.
module mono_data_tx_emu
  import mono_tx_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int DATA_DLY = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CONF_EN,
  input  logic              CONF_DISABLE_GRAY_ENC,
  input  logic              HIT_WRITE,
  input  logic [WORD_W-1:0] HIT_DATA,
  output logic              HIT_FULL,
  input  logic              TX_FREEZE,
  input  logic              TX_READ,
  output logic              TX_TOKEN,
  output logic              TX_DATA,
  output logic              BUSY,
  output logic [7:0]        LOST_CNT,
  output logic [7:0]        EMPTY_READ_CNT
);

  localparam int           AW       = $clog2(DEPTH);
  localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [3:0]   DLY_LOAD = 4'(DATA_DLY > 0 ? DATA_DLY - 1 : 0);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count, count_nxt;
  logic              read_q;
  tx_state_t         state;
  logic [WORD_W-1:0] sr;
  logic [4:0]        bit_cnt;
  logic [3:0]        wait_cnt;

  logic              rd_edge, pop, push, drop;
  logic [WORD_W-1:0] head, tx_word, word_in;
  logic [LE_W-1:0]   le_gray;
  logic [TE_W-1:0]   te_gray;

  assign head = mem[rd_ptr];

  gray_enc8 u_le_gray (.bin(head[WORD_W-1 -: LE_W]),      .gray(le_gray));
  gray_enc8 u_te_gray (.bin(head[WORD_W-LE_W-1 -: TE_W]), .gray(te_gray));

  assign tx_word = CONF_DISABLE_GRAY_ENC ? head
                                         : {le_gray, te_gray, head[ROW_W+COL_W-1:0]};
  // An empty read still transmits a full word, just all zeros.
  assign word_in = (count != '0) ? tx_word : '0;

  assign rd_edge   = TX_READ & ~read_q & CONF_EN & (state == IDLE);
  assign pop       = rd_edge & (count != '0);
  assign push      = HIT_WRITE & ((count != FULL_CNT) | pop);
  assign drop      = HIT_WRITE & ~push;
  assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= HIT_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      read_q         <= 1'b0;
      state          <= IDLE;
      sr             <= '0;
      bit_cnt        <= '0;
      wait_cnt       <= '0;
      HIT_FULL       <= 1'b0;
      TX_TOKEN       <= 1'b0;
      TX_DATA        <= 1'b0;
      BUSY           <= 1'b0;
      LOST_CNT       <= '0;
      EMPTY_READ_CNT <= '0;
    end else begin
      read_q   <= TX_READ;
      count    <= count_nxt;
      HIT_FULL <= (count_nxt == FULL_CNT);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop && LOST_CNT != 8'hFF) LOST_CNT <= LOST_CNT + 1'b1;

      if (!CONF_EN)        TX_TOKEN <= 1'b0;
      else if (!TX_FREEZE) TX_TOKEN <= (count != '0);

      case (state)
        IDLE: begin
          if (rd_edge) begin
            BUSY <= 1'b1;
            if (count == '0 && EMPTY_READ_CNT != 8'hFF)
              EMPTY_READ_CNT <= EMPTY_READ_CNT + 1'b1;
            if (DATA_DLY > 0) begin
              state    <= WAIT;
              wait_cnt <= DLY_LOAD;
              sr       <= word_in;
            end else begin
              // Bit 29 goes out straight away so it appears the cycle after the edge.
              state   <= SHIFT;
              TX_DATA <= word_in[WORD_W-1];
              sr      <= word_in << 1;
              bit_cnt <= 5'd29;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            state   <= SHIFT;
            TX_DATA <= sr[WORD_W-1];
            sr      <= sr << 1;
            bit_cnt <= 5'd29;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        SHIFT: begin
          if (bit_cnt == '0) begin
            state   <= IDLE;
            TX_DATA <= 1'b0;
            BUSY    <= 1'b0;
          end else begin
            TX_DATA <= sr[WORD_W-1];
            sr      <= sr << 1;
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          TX_DATA <= 1'b0;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mono_data_tx_emu.sv
// Directed bench for mono_data_tx_emu: one instance with DATA_DLY=0, one with DATA_DLY=3.
module tb_mono_data_tx_emu;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CONF_EN = 1'b1;
  logic        gray_off = 1'b0;
  logic        HIT_WRITE = 1'b0;
  logic [29:0] HIT_DATA = '0;
  logic        TX_FREEZE = 1'b0;
  logic        rd0 = 1'b0, rd1 = 1'b0;

  logic       full0, tok0, txd0, busy0, full1, tok1, txd1, busy1;
  logic [7:0] lost0, er0, lost1, er1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  mono_data_tx_emu #(.DEPTH(16), .DATA_DLY(0)) dut0 (
    .CLK(CLK), .RST(RST), .CONF_EN(CONF_EN), .CONF_DISABLE_GRAY_ENC(gray_off),
    .HIT_WRITE(HIT_WRITE), .HIT_DATA(HIT_DATA), .HIT_FULL(full0),
    .TX_FREEZE(TX_FREEZE), .TX_READ(rd0), .TX_TOKEN(tok0), .TX_DATA(txd0),
    .BUSY(busy0), .LOST_CNT(lost0), .EMPTY_READ_CNT(er0)
  );

  mono_data_tx_emu #(.DEPTH(16), .DATA_DLY(3)) dut1 (
    .CLK(CLK), .RST(RST), .CONF_EN(CONF_EN), .CONF_DISABLE_GRAY_ENC(gray_off),
    .HIT_WRITE(HIT_WRITE), .HIT_DATA(HIT_DATA), .HIT_FULL(full1),
    .TX_FREEZE(TX_FREEZE), .TX_READ(rd1), .TX_TOKEN(tok1), .TX_DATA(txd1),
    .BUSY(busy1), .LOST_CNT(lost1), .EMPTY_READ_CNT(er1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] gray8(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [29:0] mk_hit(input int i);
    logic [7:0] le, te, row;
    logic [5:0] col;
    le  = 8'(i * 13);
    te  = 8'(200 - i * 5);
    row = 8'(i);
    col = 6'(i * 3);
    return {le, te, row, col};
  endfunction

  function automatic logic [29:0] exp_gray(input int i);
    logic [29:0] h;
    h = mk_hit(i);
    return {gray8(h[29:22]), gray8(h[21:14]), h[13:0]};
  endfunction

  function automatic logic sel_tx(input int sel);
    return (sel == 0) ? txd0 : txd1;
  endfunction

  function automatic logic sel_busy(input int sel);
    return (sel == 0) ? busy0 : busy1;
  endfunction

  function automatic logic sel_tok(input int sel);
    return (sel == 0) ? tok0 : tok1;
  endfunction

  task automatic write_hit(input logic [29:0] d);
    HIT_DATA  = d;
    HIT_WRITE = 1'b1;
    tick();
    HIT_WRITE = 1'b0;
  endtask

  // Pulse TX_READ, then collect the serial word. busy_n counts BUSY samples including
  // the first cycle after the word, so a clean transfer yields exactly dly+30.
  task automatic read_word(input int sel, input int dly, output logic [29:0] w,
                           output int busy_n, output logic tok_a, output logic tok_b);
    if (sel == 0) rd0 = 1'b1; else rd1 = 1'b1;
    tick();
    rd0 = 1'b0;
    rd1 = 1'b0;
    tok_a  = sel_tok(sel);
    tok_b  = 1'b0;
    busy_n = 0;
    w      = '0;
    for (int c = 0; c < dly + 30; c++) begin
      if (c == 1) tok_b = sel_tok(sel);
      if (sel_busy(sel)) busy_n++;
      if (c >= dly) w[29 - (c - dly)] = sel_tx(sel);
      tick();
    end
    if (sel_busy(sel)) busy_n++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [29:0] w;
    logic [29:0] hit0;
    int          bn;
    logic        ta, tb;

    repeat (3) tick();
    check("rst_token", tok0, 0);
    check("rst_txdata", txd0, 0);
    check("rst_busy", busy0, 0);
    check("rst_full", full0, 0);
    check("rst_lost", lost0, 0);
    check("rst_empty_rd", er0, 0);
    RST = 1'b0;
    tick();

    // Gray path: le=05 te=03 row=12 col=2A
    hit0 = {8'h05, 8'h03, 8'h12, 6'h2A};
    write_hit(hit0);
    check("tok_after_write_k", tok0, 0);
    tick();
    check("tok_after_write_k1", tok0, 1);
    read_word(0, 0, w, bn, ta, tb);
    check("gray_word", w, 30'h1C084AA);
    check("gray_busy_cycles", bn, 30);
    check("gray_tok_at_edge", ta, 1);
    check("gray_tok_drop", tb, 0);
    check("gray_txd_idle", txd0, 0);

    // Gray bypass on the DATA_DLY=3 instance, which still holds the same hit
    gray_off = 1'b1;
    read_word(1, 3, w, bn, ta, tb);
    check("bypass_dly3_word", w, 30'h140C4AA);
    check("bypass_dly3_busy", bn, 33);
    gray_off = 1'b0;

    // Overflow: 18 writes into 16 entries
    for (int i = 1; i <= 18; i++) begin
      HIT_DATA  = mk_hit(i);
      HIT_WRITE = 1'b1;
      tick();
    end
    HIT_WRITE = 1'b0;
    check("ovf_full", full0, 1);
    check("ovf_lost", lost0, 2);
    for (int i = 1; i <= 16; i++) begin
      read_word(0, 0, w, bn, ta, tb);
      check($sformatf("ovf_word_%0d", i), w, exp_gray(i));
      if (i == 1) check("ovf_full_after_pop", full0, 0);
    end
    check("ovf_tok_drained", tok0, 0);
    check("ovf_lost_hold", lost0, 2);

    // Freeze holds the token across the last pop
    write_hit(mk_hit(20));
    tick();
    TX_FREEZE = 1'b1;
    read_word(0, 0, w, bn, ta, tb);
    check("frz_word", w, exp_gray(20));
    check("frz_tok_held_early", tb, 1);
    check("frz_tok_held_late", tok0, 1);
    TX_FREEZE = 1'b0;
    check("frz_tok_before_release", tok0, 1);
    tick();
    check("frz_tok_fall", tok0, 0);

    // Empty read
    read_word(0, 0, w, bn, ta, tb);
    check("empty_word", w, 0);
    check("empty_busy", bn, 30);
    check("empty_cnt", er0, 1);

    // Re-pulse during SHIFT must not be queued
    write_hit(mk_hit(21));
    rd0 = 1'b1;
    tick();
    rd0 = 1'b0;
    repeat (5) tick();
    check("repulse_busy_mid", busy0, 1);
    rd0 = 1'b1;
    tick();
    rd0 = 1'b0;
    repeat (40) tick();
    check("repulse_busy_done", busy0, 0);
    check("repulse_empty_cnt", er0, 1);
    check("repulse_tok", tok0, 0);

    // Reset while bit 15 is on the line
    write_hit(mk_hit(22));
    write_hit(mk_hit(23));
    tick();
    rd0 = 1'b1;
    tick();
    rd0 = 1'b0;
    repeat (14) tick();
    w = exp_gray(22);
    check("mid_bit15", txd0, w[15]);
    RST = 1'b1;
    tick();
    check("mid_rst_txd", txd0, 0);
    check("mid_rst_busy", busy0, 0);
    check("mid_rst_tok", tok0, 0);
    check("mid_rst_lost", lost0, 0);
    RST = 1'b0;
    repeat (2) tick();
    check("post_rst_tok", tok0, 0);
    read_word(0, 0, w, bn, ta, tb);
    check("post_rst_empty_word", w, 0);
    check("post_rst_empty_cnt", er0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
